// File: rtl/rbg_frame_sequencer_pkg.sv
// Shared types and sizing helpers for the RBG frame sequencer.
package rbg_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_FILL = 3'd2,
    ST_OUT  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // RS(255,223) style defaults
  localparam int DEF_SYM_WIDTH  = 8;
  localparam int DEF_MSG_LEN    = 223;
  localparam int DEF_TICK_DIV   = 1;
  localparam int DEF_GAP_CYCLES = 4;

  // Width needed to hold 0..max_val; never narrower than one bit so that
  // a zero-length gap still yields a legal counter.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rbg_frame_sequencer_if.sv
// Generator control and symbol stream bundle between the sequencer and its
// neighbours (bit generator upstream, RS encoder downstream).
interface rbg_frame_sequencer_if #(
  parameter int SYM_WIDTH = 8
);
  logic                 gen_load;
  logic                 gen_step;
  logic                 gen_bit;
  logic [SYM_WIDTH-1:0] sym_data;
  logic                 sym_valid;
  logic                 sym_ready;
  logic                 sym_sof;
  logic                 sym_eof;

  modport master (
    output gen_load, gen_step, sym_data, sym_valid, sym_sof, sym_eof,
    input  gen_bit, sym_ready
  );

  modport slave (
    input  gen_load, gen_step, sym_data, sym_valid, sym_sof, sym_eof,
    output gen_bit, sym_ready
  );
endinterface

// File: rtl/rbg_frame_sequencer_tick_enable_gen.sv
// Clock-enable generator: one-cycle tick every TICK_DIV enabled cycles.
// Used instead of a divided clock so the generator stays on clk_in.
module tick_enable_gen
  import rbg_frame_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic i_clk_in,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);
  localparam int             W    = cnt_width(TICK_DIV);
  localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

  logic [W-1:0] r_cnt;
  logic         w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_tick    = i_en & w_at_last;

  // Count 0..TICK_DIV-1 while enabled; clear restarts phase at zero.
  always_ff @(posedge i_clk_in) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/rbg_frame_sequencer.sv
// Sequences the random bit generator into RS message frames: steps it by
// clock enable, packs bits MSB-first into symbols and streams MSG_LEN
// symbols per frame over valid/ready.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | one cycle, generator reloads its seed
// FILL  | stepping generator, shifting SYM_WIDTH bits into the packer
// OUT   | symbol presented, waiting for sym_ready
// GAP   | idle spacing between back-to-back frames (no reload)
module rbg_frame_sequencer
  import rbg_frame_sequencer_pkg::*;
#(
  parameter int SYM_WIDTH  = DEF_SYM_WIDTH,
  parameter int MSG_LEN    = DEF_MSG_LEN,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                  i_clk_in,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_continuous,
  rbg_frame_sequencer_if.master io_bus,
  output logic                  o_busy,
  output logic [15:0]           o_frame_cnt
);
  localparam int BIT_W = cnt_width(SYM_WIDTH);
  localparam int IDX_W = cnt_width(MSG_LEN);
  localparam int GAP_W = cnt_width(GAP_CYCLES);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SYM_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);
  // Unreachable when GAP_CYCLES==0 (GAP is skipped), kept in range anyway.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t               r_state;
  logic [SYM_WIDTH-1:0] r_shift;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [IDX_W-1:0]     r_sym_idx;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic                 r_stop_pend;
  logic                 r_gen_load;
  logic                 r_sym_valid;
  logic                 r_sym_sof;
  logic                 r_sym_eof;
  logic [15:0]          r_frame_cnt;

  logic                 w_in_fill;
  logic                 w_tick;

  assign w_in_fill = (r_state == ST_FILL);

  // Tick phase restarts at zero on every entry to FILL.
  tick_enable_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_clk_in (i_clk_in),
    .i_rst    (i_rst),
    .i_clr    (~w_in_fill),
    .i_en     (w_in_fill),
    .o_tick   (w_tick)
  );

  // gen_step is a decode of registered state/counter, so it is glitch-free
  // and can only ever be high inside FILL.
  assign io_bus.gen_step  = w_tick;
  assign io_bus.gen_load  = r_gen_load;
  assign io_bus.sym_data  = r_shift;
  assign io_bus.sym_valid = r_sym_valid;
  assign io_bus.sym_sof   = r_sym_sof;
  assign io_bus.sym_eof   = r_sym_eof;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_frame_cnt      = r_frame_cnt;

  // Frame FSM with packer, symbol/gap counters and registered outputs.
  always_ff @(posedge i_clk_in) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_sym_idx   <= '0;
      r_gap_cnt   <= '0;
      r_stop_pend <= 1'b0;
      r_gen_load  <= 1'b0;
      r_sym_valid <= 1'b0;
      r_sym_sof   <= 1'b0;
      r_sym_eof   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_gen_load <= 1'b0;

      // A stop request is remembered until the current frame completes;
      // in IDLE it is ignored so start&stop together still runs.
      if (r_state != ST_IDLE && i_stop) begin
        r_stop_pend <= 1'b1;
      end

      unique case (r_state)
        ST_IDLE: begin
          r_stop_pend <= 1'b0;
          if (i_start) begin
            r_gen_load <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          r_sym_idx <= '0;
          r_bit_cnt <= '0;
          r_state   <= ST_FILL;
        end

        ST_FILL: begin
          if (w_tick) begin
            r_shift <= {r_shift[SYM_WIDTH-2:0], io_bus.gen_bit};
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt   <= '0;
              r_sym_valid <= 1'b1;
              r_sym_sof   <= (r_sym_idx == '0);
              r_sym_eof   <= (r_sym_idx == IDX_LAST);
              r_state     <= ST_OUT;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end
        end

        ST_OUT: begin
          if (io_bus.sym_ready) begin
            r_sym_valid <= 1'b0;
            r_sym_sof   <= 1'b0;
            r_sym_eof   <= 1'b0;
            if (r_sym_idx != IDX_LAST) begin
              r_sym_idx <= r_sym_idx + IDX_W'(1);
              r_state   <= ST_FILL;
            end else begin
              r_frame_cnt <= r_frame_cnt + 16'd1;
              if (r_stop_pend || !i_continuous) begin
                r_stop_pend <= 1'b0;
                r_state     <= ST_IDLE;
              end else if (GAP_CYCLES == 0) begin
                r_sym_idx <= '0;
                r_state   <= ST_FILL;
              end else begin
                r_gap_cnt <= '0;
                r_state   <= ST_GAP;
              end
            end
          end
        end

        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= '0;
            if (r_stop_pend) begin
              r_stop_pend <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_sym_idx <= '0;
              r_state   <= ST_FILL;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rbg_frame_sequencer.sv
// Scoreboard bench for rbg_frame_sequencer: a behavioural bit generator,
// expected frames derived from the bit stream, and a decoupled monitor.
module tb_rbg_frame_sequencer;
  localparam int SW = 8;
  localparam int ML = 4;
  localparam int TD = 2;
  localparam int GC = 3;
  localparam int NB = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, continuous, busy;
  logic [15:0] frame_cnt;
  logic        start1, stop1, cont1, busy1;
  logic [15:0] frame_cnt1;

  always #5 clk = ~clk;

  rbg_frame_sequencer_if #(.SYM_WIDTH(SW)) bus ();
  rbg_frame_sequencer_if #(.SYM_WIDTH(SW)) bus1 ();

  rbg_frame_sequencer #(
    .SYM_WIDTH(SW), .MSG_LEN(ML), .TICK_DIV(TD), .GAP_CYCLES(GC)
  ) u_dut (
    .i_clk_in(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
    .i_continuous(continuous), .io_bus(bus), .o_busy(busy), .o_frame_cnt(frame_cnt)
  );

  rbg_frame_sequencer #(
    .SYM_WIDTH(SW), .MSG_LEN(1), .TICK_DIV(TD), .GAP_CYCLES(GC)
  ) u_dut1 (
    .i_clk_in(clk), .i_rst(rst), .i_start(start1), .i_stop(stop1),
    .i_continuous(cont1), .io_bus(bus1), .o_busy(busy1), .o_frame_cnt(frame_cnt1)
  );

  // Behavioural generator: a fixed bit sequence, rewound by gen_load.
  bit bits [NB];
  int gpos  = 0;
  int gpos1 = 0;

  always @(posedge clk) begin
    if (bus.gen_load) gpos <= 0;
    else if (bus.gen_step) gpos <= gpos + 1;
    if (bus1.gen_load) gpos1 <= 0;
    else if (bus1.gen_step) gpos1 <= gpos1 + 1;
  end

  assign bus.gen_bit  = bits[gpos % NB];
  assign bus1.gen_bit = bits[gpos1 % NB];

  // n-th symbol of the stream since seed load: bits n*SW.. first bit in MSB.
  function automatic logic [SW-1:0] sym_at(input int n);
    logic [SW-1:0] s;
    for (int b = 0; b < SW; b++) s[SW-1-b] = bits[(n * SW + b) % NB];
    return s;
  endfunction

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    errors++;
    $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) fail(name, act, exp);
  endtask

  // Scoreboard entries; lat = cycles from the latest gen_load or handshake
  // to the rising edge of sym_valid for this symbol.
  typedef struct {
    logic [SW-1:0] data;
    logic          sof;
    logic          eof;
    int            lat;
  } exp_t;

  exp_t q[$];
  int   stream_sym = 0;

  task automatic push_frame(input bit fresh, input bit after_gap);
    exp_t e;
    if (fresh) stream_sym = 0;
    for (int i = 0; i < ML; i++) begin
      e.data = sym_at(stream_sym);
      stream_sym++;
      e.sof  = (i == 0);
      e.eof  = (i == ML - 1);
      e.lat  = SW * TD + 1 + ((i == 0 && after_gap) ? GC : 0);
      q.push_back(e);
    end
  endtask

  // Monitor
  int            ref_cyc    = 0;
  int            hs_count   = 0;
  int            load_count = 0;
  int            step_count = 0;
  logic          prev_valid = 1'b0;
  logic          prev_stall = 1'b0;
  logic [SW-1:0] prev_data;
  logic          prev_sof, prev_eof;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (bus.gen_load && bus.gen_step) fail("load_step_overlap", 1, 0);
      checks++;
      if (bus.gen_step && (bus.sym_valid || !busy)) fail("step_outside_fill", 1, 0);
      if (prev_stall) begin
        checks++;
        if (!bus.sym_valid || bus.sym_data !== prev_data ||
            bus.sym_sof !== prev_sof || bus.sym_eof !== prev_eof)
          fail("hold_stable", {bus.sym_valid, bus.sym_sof, bus.sym_eof, bus.sym_data},
               {1'b1, prev_sof, prev_eof, prev_data});
      end
      if (bus.gen_load) begin
        ref_cyc = cyc;
        load_count++;
      end
      if (bus.gen_step) step_count++;
      if (bus.sym_valid && !prev_valid) begin
        checks++;
        if (q.size() == 0) fail("unexpected_valid", 1, 0);
        else if (cyc - ref_cyc != q[0].lat) fail("valid_latency", cyc - ref_cyc, q[0].lat);
      end
      if (bus.sym_valid && bus.sym_ready) begin
        checks++;
        if (q.size() == 0) begin
          fail("unexpected_symbol", bus.sym_data, 0);
        end else begin
          e = q.pop_front();
          if (bus.sym_data !== e.data) fail("sym_data", bus.sym_data, e.data);
          checks++;
          if ({bus.sym_sof, bus.sym_eof} !== {e.sof, e.eof})
            fail("sof_eof", {bus.sym_sof, bus.sym_eof}, {e.sof, e.eof});
        end
        hs_count++;
        ref_cyc = cyc;
      end
      prev_valid = bus.sym_valid;
      prev_stall = bus.sym_valid && !bus.sym_ready;
      prev_data  = bus.sym_data;
      prev_sof   = bus.sym_sof;
      prev_eof   = bus.sym_eof;
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the active edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic wait_hs(input string name, input int target, input int budget);
    int n = 0;
    while (hs_count < target && n < budget) begin
      tick(1);
      n++;
    end
    check(name, (hs_count >= target), 1'b1);
  endtask

  initial begin
    int n, c_load, loads0, steps0, hs0;
    logic [15:0] fc0;

    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    start1 = 1'b0; stop1 = 1'b0; cont1 = 1'b0;
    bus.sym_ready = 1'b1; bus1.sym_ready = 1'b1;
    for (int i = 0; i < NB; i++) bits[i] = bit'($urandom_range(0, 1));
    {bits[0], bits[1], bits[2], bits[3], bits[4], bits[5], bits[6], bits[7]} = 8'b1011_0010;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Reset in the middle of FILL
    pulse_start();
    tick(6);
    check("mid_fill_busy", busy, 1'b1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", bus.sym_valid, 1'b0);
    check("rst_load_step", {bus.gen_load, bus.gen_step}, 2'b00);
    check("rst_sof_eof", {bus.sym_sof, bus.sym_eof}, 2'b00);
    check("rst_data", bus.sym_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);

    // Packing, latency and a single frame
    push_frame(1'b1, 1'b0);
    pulse_start();
    n = 0;
    while (!bus.gen_load && n < 8) begin tick(1); n++; end
    check("gen_load_seen", bus.gen_load, 1'b1);
    c_load = cyc;
    tick(1);
    check("gen_load_one_cycle", bus.gen_load, 1'b0);
    n = 0;
    while (!bus.sym_valid && n < 40) begin tick(1); n++; end
    check("first_latency", cyc - c_load, SW * TD + 1);
    check("first_data", bus.sym_data, 8'hB2);
    check("first_sof", bus.sym_sof, 1'b1);
    wait_idle("single_frame_idle", 200);
    check("single_frame_cnt", frame_cnt, 1);
    check("single_frame_drained", q.size(), 0);

    // Backpressure on symbol #1
    push_frame(1'b1, 1'b0);
    hs0 = hs_count;
    pulse_start();
    wait_hs("bp_sym0", hs0 + 1, 60);
    bus.sym_ready = 1'b0;
    n = 0;
    while (!bus.sym_valid && n < 40) begin tick(1); n++; end
    check("bp_valid", bus.sym_valid, 1'b1);
    steps0 = step_count;
    tick(10);
    check("bp_no_steps", step_count - steps0, 0);
    check("bp_still_valid", bus.sym_valid, 1'b1);
    check("bp_eof_low", bus.sym_eof, 1'b0);
    bus.sym_ready = 1'b1;
    wait_idle("bp_idle", 200);
    check("bp_frame_cnt", frame_cnt, 2);

    // Continuous with stop during frame 2 symbol #1
    continuous = 1'b1;
    push_frame(1'b1, 1'b0);
    push_frame(1'b0, 1'b1);
    loads0 = load_count; fc0 = frame_cnt; hs0 = hs_count;
    pulse_start();
    wait_hs("cont_reach_f2", hs0 + ML + 1, 400);
    pulse_stop();
    wait_idle("cont_stop_idle", 400);
    check("cont_frame_cnt", frame_cnt, fc0 + 16'd2);
    check("cont_no_reload", load_count - loads0, 1);

    // Stop arriving during the gap
    push_frame(1'b1, 1'b0);
    fc0 = frame_cnt; hs0 = hs_count;
    pulse_start();
    wait_hs("gap_reach_end", hs0 + ML, 400);
    pulse_stop();
    wait_idle("gap_stop_idle", 40);
    check("gap_stop_frame_cnt", frame_cnt, fc0 + 16'd1);

    // Start while busy is ignored
    continuous = 1'b0;
    push_frame(1'b1, 1'b0);
    loads0 = load_count; fc0 = frame_cnt;
    pulse_start();
    tick(5);
    pulse_start();
    tick(30);
    pulse_start();
    wait_idle("busy_start_idle", 400);
    check("busy_start_loads", load_count - loads0, 1);
    check("busy_start_frames", frame_cnt, fc0 + 16'd1);

    // start&stop together in IDLE: start wins, no stop is remembered
    continuous = 1'b1;
    push_frame(1'b1, 1'b0);
    push_frame(1'b0, 1'b1);
    fc0 = frame_cnt; hs0 = hs_count;
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    wait_hs("ss_reach_f2", hs0 + ML + 1, 400);
    pulse_stop();
    wait_idle("ss_idle", 400);
    check("ss_frames", frame_cnt, fc0 + 16'd2);
    continuous = 1'b0;

    // Random consumer backpressure
    for (int r = 0; r < 3; r++) begin
      push_frame(1'b1, 1'b0);
      pulse_start();
      n = 0;
      while (busy && n < 2000) begin
        bus.sym_ready = 1'($urandom_range(0, 1));
        tick(1);
        n++;
      end
      bus.sym_ready = 1'b1;
      wait_idle("rand_idle", 200);
    end
    check("all_drained", q.size(), 0);

    // MSG_LEN=1: every symbol is both first and last
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    n = 0;
    while (!bus1.sym_valid && n < 40) begin tick(1); n++; end
    check("len1_valid", bus1.sym_valid, 1'b1);
    check("len1_sof_eof", {bus1.sym_sof, bus1.sym_eof}, 2'b11);
    check("len1_data", bus1.sym_data, sym_at(0));
    n = 0;
    while (busy1 && n < 40) begin tick(1); n++; end
    check("len1_idle", busy1, 1'b0);
    check("len1_frame_cnt", frame_cnt1, 1);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
